// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl: program-counter register, run/halt state machine and
// statistics counters.
// Ports: in_clk/in_rst (async, active-high) clock and reset.
//        in_pcin selected next PC; in_stall, in_halt, in_go, in_J and
//        in_br_taken are the control inputs.
//        out_pc/out_pcc are the fetch address and PC+4; out_running is 1 in RUN.
//        out_cyc_cnt/out_jmp_cnt/out_br_cnt are the statistics counters.
module pc_run_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [31:0]      in_pcin,
    input  logic             in_stall,
    input  logic             in_halt,
    input  logic             in_go,
    input  logic             in_J,
    input  logic             in_br_taken,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pcc,
    output logic             out_running,
    output logic [CNT_W-1:0] out_cyc_cnt,
    output logic [CNT_W-1:0] out_jmp_cnt,
    output logic [CNT_W-1:0] out_br_cnt
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             go_q;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] jmp_q, jmp_d;
    logic [CNT_W-1:0] br_q, br_d;

    logic run;
    logic retire;
    logic go_edge;
    logic count_ok;

    assign run      = (state_q == S_RUN);
    assign retire   = run & ~in_stall;
    assign go_edge  = in_go & ~go_q;
    // A retiring halt is not a jump or branch, even if those flags are set.
    assign count_ok = retire & ~in_halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_RUN: begin
                if (retire) begin
                    if (in_halt) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d = in_pcin;
                    end
                end
            end
            S_HALTED: begin
                // Resume steps past the halt instruction.
                if (go_edge) begin
                    pc_d    = in_pcin;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        cyc_d = run ? cyc_q + ONE : cyc_q;
        jmp_d = (count_ok & in_J) ? jmp_q + ONE : jmp_q;
        br_d  = (count_ok & in_br_taken) ? br_q + ONE : br_q;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            go_q    <= 1'b0;
            cyc_q   <= '0;
            jmp_q   <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            go_q    <= in_go;
            cyc_q   <= cyc_d;
            jmp_q   <= jmp_d;
            br_q    <= br_d;
        end
    end

    assign out_pc      = pc_q;
    assign out_pcc     = pc_q + 32'd4;
    assign out_running = run;
    assign out_cyc_cnt = cyc_q;
    assign out_jmp_cnt = jmp_q;
    assign out_br_cnt  = br_q;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// tb_pc_run_ctrl: bench for pc_run_ctrl with CNT_W=4 so counter
// wrap is reachable; outputs compared against a behavioural model.
module tb_pc_run_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pcin = '0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          go = 1'b0;
    logic          jf = 1'b0;
    logic          brt = 1'b0;
    logic [31:0]   pc;
    logic [31:0]   pcc;
    logic          running;
    logic [CW-1:0] cyc;
    logic [CW-1:0] jmp;
    logic [CW-1:0] br;

    int vec = 0;
    int bad = 0;

    logic [31:0]   m_pc;
    logic          m_run;
    logic [CW-1:0] m_cyc, m_jmp, m_br;
    logic          m_go;

    pc_run_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .in_clk(clk), .in_rst(rst), .in_pcin(pcin), .in_stall(stall),
        .in_halt(halt), .in_go(go), .in_J(jf), .in_br_taken(brt),
        .out_pc(pc), .out_pcc(pcc), .out_running(running),
        .out_cyc_cnt(cyc), .out_jmp_cnt(jmp), .out_br_cnt(br)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_pc = 32'h0; m_run = 1'b1; m_go = 1'b0;
        m_cyc = '0; m_jmp = '0; m_br = '0;
    endtask

    // Advance one clock; the model applies the rules to the inputs
    // present at the edge.
    task automatic step();
        logic edge_go;
        @(posedge clk);
        edge_go = go && !m_go;
        if (m_run) begin
            m_cyc = m_cyc + 1'b1;
            if (!stall) begin
                if (halt) m_run = 1'b0;
                else begin
                    m_pc = pcin;
                    if (jf) m_jmp = m_jmp + 1'b1;
                    if (brt) m_br = m_br + 1'b1;
                end
            end
        end else if (edge_go) begin
            m_pc = pcin;
            m_run = 1'b1;
        end
        m_go = go;
        #1;
    endtask

    function automatic logic [76:0] expv();
        return {m_pc, m_pc + 32'd4, m_run, m_cyc, m_jmp, m_br};
    endfunction

    function automatic logic [76:0] actv();
        return {pc, pcc, running, cyc, jmp, br};
    endfunction

    task automatic idle();
        pcin = '0; stall = 0; halt = 0; go = 0; jf = 0; brt = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        vec++;
        if (actv() !== expv() || pc !== 32'h0 || pcc !== 32'h4) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", actv(), expv());
        end
        @(posedge clk);
        #1;
        vec++;
        if (actv() !== expv()) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", actv(), expv());
        end
        rst = 1'b0;
    endtask

    task automatic test_seq();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pcin = m_pc + 32'd4;
            step();
            vec++;
            if (actv() !== expv() || pc !== 32'(4 * (i + 1))) begin
                bad++;
                $display("FAIL seq_%0d: got %h want %h", i, actv(), expv());
            end
        end
        vec++;
        if (cyc !== 4'd5 || jmp !== 4'd0 || br !== 4'd0) begin
            bad++;
            $display("FAIL seq_cnt: got %0d/%0d/%0d want 5/0/0", cyc, jmp, br);
        end
    endtask

    task automatic test_jump();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int i = 0; i < 2; i++) begin
                pcin = m_pc + 32'd4;
                step();
            end
            jf = 1'b1; pcin = 32'h40; stall = (s == 1);
            step();
            idle();
            vec++;
            if (actv() !== expv()) begin
                bad++;
                $display("FAIL jump_s%0d: got %h want %h", s, actv(), expv());
            end
            vec++;
            if (pc !== (s == 1 ? 32'h8 : 32'h40) || cyc !== 4'd3) begin
                bad++;
                $display("FAIL jump_pc_s%0d: got %h/%0d", s, pc, cyc);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pcin = m_pc + 32'd4;
            step();
        end
        halt = 1'b1; pcin = 32'h14;
        step();
        halt = 1'b0;
        vec++;
        if (actv() !== expv() || pc !== 32'h10 || running !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter: got %h want %h", actv(), expv());
        end
        for (int i = 0; i < 10; i++) begin
            pcin = $urandom; stall = 1'($urandom);
            jf = 1'($urandom); brt = 1'($urandom);
            step();
            vec++;
            if (actv() !== expv()) begin
                bad++;
                $display("FAIL halt_hold_%0d: got %h want %h", i, actv(), expv());
            end
        end
        idle();
        go = 1'b1; pcin = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step();
            pcin = 32'h100 + 32'(i * 4);
            vec++;
            if (actv() !== expv()) begin
                bad++;
                $display("FAIL resume_%0d: got %h want %h", i, actv(), expv());
            end
        end
        go = 1'b0;
    endtask

    task automatic test_halt_stall();
        do_reset();
        halt = 1'b1; stall = 1'b1; pcin = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++;
            if (actv() !== expv() || running !== 1'b1) begin
                bad++;
                $display("FAIL hstall_%0d: got %h want %h", i, actv(), expv());
            end
        end
        stall = 1'b0;
        step();
        vec++;
        if (actv() !== expv() || running !== 1'b0) begin
            bad++;
            $display("FAIL hstall_drop: got %h want %h", actv(), expv());
        end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        brt = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pcin = m_pc + 32'd4;
            step();
        end
        idle();
        vec++;
        if (actv() !== expv() || br !== 4'd1 || cyc !== 4'd1) begin
            bad++;
            $display("FAIL wrap: got %h want %h", actv(), expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pcin  = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 11) == 0);
            go    = ($urandom_range(0, 2) == 0);
            jf    = 1'($urandom);
            brt   = 1'($urandom);
            step();
            vec++;
            if (actv() !== expv()) begin
                bad++;
                $display("FAIL rand_%0d: got %h want %h", i, actv(), expv());
            end
        end
        idle();
    endtask

    task automatic test_reset_midhalt();
        do_reset();
        halt = 1'b1;
        step();
        idle();
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vec++;
        if (actv() !== expv() || running !== 1'b1) begin
            bad++;
            $display("FAIL reset_midhalt: got %h want %h", actv(), expv());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_jump();
        test_halt();
        test_halt_stall();
        test_wrap();
        test_random();
        test_reset_midhalt();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
